mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Sequential, parametrised MixColumns engine for the AES datapath.
- Supports forward MixColumns, InvMixColumns and bypass, for both encrypt and decrypt rounds and the final round.
- Processes COLS_PER_CYCLE 32-bit columns per clock, so area and throughput are traded off at elaboration time.
- Sits between ShiftRows/InvShiftRows and AddRoundKey; uses valid/ready handshakes on both sides.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 or 4; any other value is an elaboration error.
- NUM_PASSES, 4/COLS_PER_CYCLE, derived and not overridable; number of compute cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in/mode/skip are valid
- in_ready  output  1  engine can accept a block
- state_in  input  128  AES state; column c = bits [c*32+:32], row 0 byte at c*32+24
- mode  input  1  0 = forward MixColumns, 1 = InvMixColumns
- skip  input  1  1 = bypass (final round); output equals input
- out_valid  output  1  state_out is valid
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  transformed state, same column/byte layout as state_in
- busy  output  1  high in COMPUTE or DONE

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0; busy=0; state_out=0; internal column counter=0; captured mode/skip=0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture state_in, mode and skip into the working register; counter=0; go to COMPUTE.
- COMPUTE:
  - in_ready=0.
  - Each cycle transforms columns in order 3,2,1,0 (bits 127:96 first), COLS_PER_CYCLE columns per cycle, writing results in place.
  - After pass NUM_PASSES-1: go to DONE.
  - Input changes during COMPUTE are ignored.
- DONE:
  - out_valid=1; state_out holds the result and is stable.
  - On out_ready=1: out_valid drops next cycle; go to IDLE.
  - in_ready=0 in DONE, so no same-cycle accept. Minimum initiation interval = NUM_PASSES+2 cycles.
- Latency: acceptance edge to out_valid high = NUM_PASSES cycles (4 / 2 / 1).
- Forward matrix per column (a0..a3, a0 = row 0):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
- Arithmetic: GF(2^8) with polynomial 0x11b.
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0), truncated to 8 bits.
  - Constants 09/0b/0d/0e are built from repeated xtime and XOR.
  - All arithmetic is 8-bit; there is no carry.
- skip=1: latency and handshake identical to a normal block; column data passes unmodified; mode is ignored.
- Back-pressure: DONE may be held indefinitely. state_out and out_valid must not change until out_ready.
- Reset mid-COMPUTE or mid-DONE: immediate return to the reset values above; the partial result is discarded, and no out_valid pulse appears afterwards.
- Purely synchronous, single clock; no combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- Forward FIPS-197 vector, COLS_PER_CYCLE=1: state_in=db135345_f20a225c_01010101_c6c6c6c6, mode=0, skip=0 -> out_valid exactly 4 cycles after acceptance; state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Inverse round-trip: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode=1 -> state_out=db135345_f20a225c_01010101_c6c6c6c6. Repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Bypass: state_in=d4d4d4d5_2d26314c_00000000_ffffffff, skip=1, mode=1 -> state_out identical to input; latency equal to NUM_PASSES.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid rises -> state_out and out_valid stable, in_ready=0 throughout. Then out_ready=1 for one cycle -> IDLE next cycle, in_ready=1. A second block with input d4d4d4d5_2d26314c_… gives columns d5d5d7d6 and 4d7ebdf8.
- Reset mid-compute: assert rst asynchronously 2 cycles after acceptance (COLS_PER_CYCLE=1) -> out_valid=0, state_out=0, in_ready=1 immediately; no out_valid before a new acceptance.
- Input glitch: change state_in and mode every cycle during COMPUTE -> result matches the captured block only (first vector).

Source files
------------

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns / InvMixColumns / bypass engine.
// Transforms COLS_PER_CYCLE 32-bit columns per clock, in place, in the order 3,2,1,0.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   state_in/mode/skip are valid
//   in_ready   engine can accept a block (IDLE only)
//   state_in   128-bit AES state, column c = bits [c*32+:32], row 0 byte at c*32+24
//   mode       0 = forward MixColumns, 1 = InvMixColumns
//   skip       1 = bypass, data returned unmodified
//   out_valid  state_out holds the result (DONE)
//   out_ready  downstream accepts state_out
//   state_out  transformed state, same layout as state_in
//   busy       high in COMPUTE or DONE
module mix_columns_seq #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         mode,
   input  logic         skip,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam int unsigned NUM_PASSES = 4 / COLS_PER_CYCLE;

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

   state_e         state_q, state_d;
   logic [127:0]   data_q, data_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           mode_q, mode_d;
   logic           skip_q, skip_d;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column; a0 is the row-0 byte in the top bits.
   function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
      logic [7:0] a [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x4, x8;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         m2[i] = xtime(a[i]);
         m3[i] = m2[i] ^ a[i];
         x4    = xtime(m2[i]);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ m2[i] ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ m2[i];
      end
      if (inv) begin
         r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
      end else begin
         r = {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
              a[0]  ^ m2[1] ^ m3[2] ^ a[3],
              a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
              m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
      end
      return r;
   endfunction

   always_comb begin
      logic [1:0] col;
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      skip_d  = skip_q;
      col     = 2'd0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = state_in;
               mode_d  = mode;
               skip_d  = skip;
               cnt_d   = 2'd0;
               state_d = StCompute;
            end
         end
         StCompute: begin
            // Pass cnt_q handles columns 3-(cnt*CPC+k); the first pass takes bits 127:96.
            for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
               col = 2'(3 - (int'(cnt_q) * int'(COLS_PER_CYCLE) + k));
               if (!skip_q) begin
                  data_d[32*col +: 32] = mix_col(data_q[32*col +: 32], mode_q);
               end
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(NUM_PASSES - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= 2'd0;
         mode_q  <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         skip_q  <= skip_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign state_out = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (COLS_PER_CYCLE = 1, 2, 4) share stimulus and
// are checked against a matrix-based GF(2^8) reference model.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] state_in;
   logic         mode;
   logic         skip;
   logic         out_ready;
   logic [2:0]   in_ready;
   logic [2:0]   out_valid;
   logic [2:0]   busy;
   logic [127:0] state_out [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready[g]),
         .state_in  (state_in),
         .mode      (mode),
         .skip      (skip),
         .out_valid (out_valid[g]),
         .out_ready (out_ready),
         .state_out (state_out[g]),
         .busy      (busy[g])
      );
   end

   // Generic shift-and-add GF(2^8) multiply, polynomial 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Circulant matrix: entry (r, j) = coef[(j - r) mod 4].
   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv,
                                            input logic byp);
      logic [7:0] coef [4];
      logic [7:0] acc;
      logic [127:0] res;
      if (byp) return s;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc ^= gmul(s[c*32 + 24 - 8*j +: 8], coef[(j - r + 4) % 4]);
            end
            res[c*32 + 24 - 8*r +: 8] = acc;
         end
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one block through all three instances. Inputs are scrambled during COMPUTE.
   // hold = extra DONE cycles with out_ready low.
   task automatic run_block(input string tag, input logic [127:0] data, input logic md,
                            input logic sk, input int hold, output logic [127:0] res1);
      logic [127:0] exp;
      exp = ref_mix(data, md, sk);
      for (int g = 0; g < 3; g++) check({tag, " in_ready idle"}, 128'(in_ready[g]), 128'd1);
      in_valid = 1'b1;
      state_in = data;
      mode     = md;
      skip     = sk;
      tick();
      for (int t = 1; t <= 4; t++) begin
         in_valid = $urandom_range(0, 1);
         state_in = {$urandom, $urandom, $urandom, $urandom};
         mode     = $urandom_range(0, 1);
         skip     = $urandom_range(0, 1);
         tick();
         for (int g = 0; g < 3; g++) begin
            check($sformatf("%s latency g%0d t%0d", tag, g, t), 128'(out_valid[g]),
                  128'(t >= (4 >> g)));
            check($sformatf("%s in_ready busy g%0d", tag, g), 128'(in_ready[g]), 128'd0);
         end
      end
      in_valid = 1'b0;
      for (int h = 0; h < hold; h++) begin
         tick();
         for (int g = 0; g < 3; g++) begin
            check($sformatf("%s hold valid g%0d", tag, g), 128'(out_valid[g]), 128'd1);
            check($sformatf("%s hold ready g%0d", tag, g), 128'(in_ready[g]), 128'd0);
            check($sformatf("%s hold data g%0d", tag, g), state_out[g], exp);
         end
      end
      for (int g = 0; g < 3; g++) begin
         check($sformatf("%s data g%0d", tag, g), state_out[g], exp);
         check($sformatf("%s busy g%0d", tag, g), 128'(busy[g]), 128'd1);
      end
      res1 = state_out[0];
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("%s release valid g%0d", tag, g), 128'(out_valid[g]), 128'd0);
         check($sformatf("%s release ready g%0d", tag, g), 128'(in_ready[g]), 128'd1);
         check($sformatf("%s release busy g%0d", tag, g), 128'(busy[g]), 128'd0);
      end
   endtask

   initial begin
      logic [127:0] res;
      rst       = 1'b1;
      in_valid  = 1'b0;
      state_in  = '0;
      mode      = 1'b0;
      skip      = 1'b0;
      out_ready = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         check("reset in_ready", 128'(in_ready[g]), 128'd1);
         check("reset out_valid", 128'(out_valid[g]), 128'd0);
         check("reset busy", 128'(busy[g]), 128'd0);
         check("reset state_out", state_out[g], 128'd0);
      end
      #12;
      rst = 1'b0;
      tick();

      run_block("fips fwd", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 0, res);
      check("fips fwd const", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      run_block("fips inv", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0, 0, res);
      check("fips inv const", res, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
      run_block("bypass", 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b1, 1'b1, 0, res);
      check("bypass const", res, 128'hd4d4d4d5_2d26314c_00000000_ffffffff);
      run_block("backpressure", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 10,
                res);
      run_block("second fwd", 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 1'b0, 0, res);
      check("second fwd const", res, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);

      for (int i = 0; i < 8; i++) begin
         run_block($sformatf("rand%0d", i), {$urandom, $urandom, $urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), res);
      end

      // Asynchronous reset two cycles into COMPUTE.
      in_valid = 1'b1;
      state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      mode     = 1'b0;
      skip     = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midrst out_valid", 128'(out_valid[0]), 128'd0);
      check("midrst state_out", state_out[0], 128'd0);
      check("midrst in_ready", 128'(in_ready[0]), 128'd1);
      check("midrst busy", 128'(busy[0]), 128'd0);
      tick();
      rst = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         for (int g = 0; g < 3; g++) begin
            check($sformatf("post-rst no valid g%0d", g), 128'(out_valid[g]), 128'd0);
         end
      end
      run_block("after rst", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 0, res);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
